// File: rtl/slow_packer_param_if.sv
// Slow-channel packer bus.
// Groups the byte-source side (frame byte, frame address, strobe, channel switch,
// packing mode) with the orbit-RAM side (packed word, write enable, write address)
// and the test/skip indicators.
//   master : the byte source / environment; drives iData, addrRam, strob, SW, mode
//   slave  : the packer; drives test, orbWord, WE, WrAddr, skip
interface slow_packer_param_if #(
    parameter int DATA_W = 8,
    parameter int WORD_W = 12,
    parameter int ADDR_W = 11
);
    logic [DATA_W-1:0] iData;
    logic [ADDR_W-1:0] addrRam;
    logic              strob;
    logic              SW;
    logic              mode;
    logic              test;
    logic [WORD_W-1:0] orbWord;
    logic              WE;
    logic [ADDR_W-1:0] WrAddr;
    logic              skip;

    modport master (
        output iData, addrRam, strob, SW, mode,
        input  test, orbWord, WE, WrAddr, skip
    );

    modport slave (
        input  iData, addrRam, strob, SW, mode,
        output test, orbWord, WE, WrAddr, skip
    );
endinterface

// File: rtl/slow_packer_param.sv
// Slow-channel packer (parametrised).
// Qualifies an asynchronous byte strobe, counts bytes within a frame, merges the
// low byte (index LO_IDX) with the low HI_BITS of the last byte into one orbital
// word and writes it to orbit RAM after a programmable write-enable delay.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : slave side of slow_packer_param_if
//          in  iData, addrRam, strob (async), SW (async), mode
//          out test, orbWord, WE, WrAddr, skip (all registered)
module slow_packer_param #(
    parameter int DATA_W    = 8,
    parameter int WORD_W    = 12,
    parameter int ADDR_W    = 11,
    parameter int FRAME_LEN = 18,
    parameter int LO_IDX    = 16,
    parameter int QUAL_LEN  = 4,
    parameter int WE_DELAY  = 28,
    parameter int WE_GUARD  = 3
) (
    input logic clk,
    input logic rst,
    slow_packer_param_if.slave bus
);
    localparam int HI_BITS = WORD_W - DATA_W - 2;
    localparam int IDX_W   = $clog2(FRAME_LEN);
    localparam int QUAL_W  = (QUAL_LEN > 1) ? $clog2(QUAL_LEN) : 1;
    localparam int CNT_W   = $clog2(WE_DELAY + WE_GUARD + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CAPT  = 2'd1,
        ST_WESET = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    // Parity bit that makes {payload, bit} odd in total.
    function automatic logic odd_parity_bit(input logic [WORD_W-2:0] payload);
        odd_parity_bit = ~(^payload);
    endfunction

    logic              str_meta_r;
    logic              str_sync_r;
    logic              sw_meta_r;
    logic              sw_sync_r;
    logic              old_sw_r;
    state_t            state_r;
    logic [QUAL_W-1:0] qual_r;
    logic [IDX_W-1:0]  idx_r;
    logic [CNT_W-1:0]  we_cnt_r;
    logic [DATA_W-1:0] lo_r;
    logic [WORD_W-1:0] orb_word_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic              we_r;
    logic              test_r;
    logic              skip_r;

    logic              sw_edge_s;
    logic              qual_done_s;
    logic              idx_last_s;
    logic [WORD_W-2:0] payload_s;
    logic [WORD_W-1:0] packed_word_s;

    assign sw_edge_s   = sw_sync_r ^ old_sw_r;
    assign qual_done_s = (qual_r == QUAL_W'(QUAL_LEN - 1));
    assign idx_last_s  = (idx_r == IDX_W'(FRAME_LEN - 1));

    // Word to store on the last byte: mode flag, high bits, low byte, parity/zero.
    always_comb begin
        payload_s = {bus.mode, bus.iData[HI_BITS-1:0], lo_r};
        if (bus.mode) begin
            packed_word_s = {payload_s, odd_parity_bit(payload_s)};
        end else begin
            packed_word_s = {payload_s, 1'b0};
        end
    end

    // Two-flop synchronisers for the asynchronous strobe and channel switch (not reset).
    always_ff @(posedge clk) begin
        str_meta_r <= bus.strob;
        str_sync_r <= str_meta_r;
        sw_meta_r  <= bus.SW;
        sw_sync_r  <= sw_meta_r;
    end

    // Frame sequencer: strobe qualification, byte capture, write-enable timing, SW abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            qual_r     <= '0;
            idx_r      <= '0;
            we_cnt_r   <= '0;
            lo_r       <= '0;
            old_sw_r   <= 1'b0;
            orb_word_r <= '0;
            wr_addr_r  <= '0;
            we_r       <= 1'b0;
            test_r     <= 1'b0;
            skip_r     <= 1'b0;
        end else begin
            old_sw_r <= sw_sync_r;
            test_r   <= sw_edge_s;
            skip_r   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // Qualification needs QUAL_LEN consecutive high samples.
                    if (str_sync_r) begin
                        if (qual_done_s) begin
                            qual_r  <= '0;
                            state_r <= ST_CAPT;
                        end else begin
                            qual_r <= qual_r + QUAL_W'(1);
                        end
                    end else begin
                        qual_r <= '0;
                    end
                end
                ST_CAPT: begin
                    state_r <= ST_WAIT;
                    // A simultaneous SW edge discards this byte entirely.
                    if (!sw_edge_s) begin
                        if (idx_last_s) begin
                            idx_r      <= '0;
                            orb_word_r <= packed_word_s;
                            if (bus.addrRam != '0) begin
                                wr_addr_r <= bus.addrRam;
                                we_cnt_r  <= '0;
                                state_r   <= ST_WESET;
                            end else begin
                                skip_r <= 1'b1;
                            end
                        end else begin
                            if (idx_r == IDX_W'(LO_IDX)) begin
                                lo_r <= bus.iData;
                            end
                            idx_r <= idx_r + IDX_W'(1);
                        end
                    end
                end
                ST_WESET: begin
                    if (sw_edge_s) begin
                        we_r    <= 1'b0;
                        state_r <= ST_WAIT;
                    end else begin
                        if (we_cnt_r == CNT_W'(WE_DELAY)) begin
                            we_r <= 1'b1;
                        end
                        // Counter holds at the terminal value so it never wraps.
                        if (we_cnt_r == CNT_W'(WE_DELAY + WE_GUARD)) begin
                            state_r <= ST_WAIT;
                        end else begin
                            we_cnt_r <= we_cnt_r + CNT_W'(1);
                        end
                    end
                end
                ST_WAIT: begin
                    // WE stays high until the strobe has fallen.
                    if (!str_sync_r) begin
                        we_r    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    we_r    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
            // Any channel switch restarts the frame count.
            if (sw_edge_s) begin
                idx_r <= '0;
            end
        end
    end

    assign bus.orbWord = orb_word_r;
    assign bus.WrAddr  = wr_addr_r;
    assign bus.WE      = we_r;
    assign bus.test    = test_r;
    assign bus.skip    = skip_r;
endmodule

// File: tb/tb_slow_packer_param.sv
module tb_slow_packer_param;
    localparam int DATA_W    = 8;
    localparam int WORD_W    = 12;
    localparam int ADDR_W    = 11;
    localparam int FRAME_LEN = 18;
    localparam int LO_IDX    = 16;
    localparam int QUAL_LEN  = 4;
    localparam int WE_DELAY  = 28;
    localparam int WE_GUARD  = 3;
    localparam int HI_BITS   = WORD_W - DATA_W - 2;
    // Cycles from strob rising (last byte) to CAPT and to WE=1.
    localparam int CAPT_CYC  = 2 + QUAL_LEN + 1;
    localparam int WE_LAT    = 2 + QUAL_LEN + 1 + WE_DELAY + 1;
    localparam int LAST_HOLD = 40;
    localparam int WIN       = 50;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   exp_orb;
    int   exp_addr;

    always #5 clk = ~clk;

    slow_packer_param_if #(.DATA_W(DATA_W), .WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus ();

    slow_packer_param #(
        .DATA_W(DATA_W), .WORD_W(WORD_W), .ADDR_W(ADDR_W), .FRAME_LEN(FRAME_LEN),
        .LO_IDX(LO_IDX), .QUAL_LEN(QUAL_LEN), .WE_DELAY(WE_DELAY), .WE_GUARD(WE_GUARD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference word: mode at MSB, hi bits, lo byte, then odd-parity or zero bit.
    function automatic int model_word(input int lo, input int hi, input int md);
        int w;
        w = md * (1 << (WORD_W - 1)) + (hi % (1 << HI_BITS)) * (1 << (DATA_W + 1)) + lo * 2;
        if (md == 1 && ($countones(w) % 2) == 0) w = w + 1;
        return w;
    endfunction

    task automatic pulse(input int hi_len, input int lo_len);
        @(negedge clk);
        bus.strob = 1'b1;
        repeat (hi_len) @(negedge clk);
        bus.strob = 1'b0;
        repeat (lo_len - 1) @(negedge clk);
    endtask

    // One full frame; the last-byte strobe is held LAST_HOLD cycles and observed.
    task automatic run_frame(input int lo, input int hi, input int addr, input int md,
                             input int sw_at, input int rst_at, input int first_len);
        int first_we, we_fall, skip_cnt, skip_at, test_cnt, test_at;
        bit did_rst;
        first_we = 0; we_fall = 0; skip_cnt = 0; skip_at = 0;
        test_cnt = 0; test_at = 0; did_rst = 1'b0;
        bus.addrRam = ADDR_W'(addr);
        for (int b = 0; b < FRAME_LEN - 1; b++) begin
            bus.iData = (b == LO_IDX) ? DATA_W'(lo) : DATA_W'($urandom);
            bus.mode  = 1'($urandom);
            pulse((b == 0) ? first_len : 6, 4);
            if (b == LO_IDX) check("we_mid_frame", 32'(bus.WE), 0);
        end
        bus.iData = DATA_W'(hi);
        bus.mode  = 1'(md);
        @(negedge clk);
        bus.strob = 1'b1;
        for (int c = 1; c <= WIN; c++) begin
            @(posedge clk);
            #1;
            if (bus.WE === 1'b1 && first_we == 0) first_we = c;
            if (bus.WE !== 1'b1 && first_we != 0 && we_fall == 0) we_fall = c;
            if (bus.skip === 1'b1) begin skip_cnt++; skip_at = c; end
            if (bus.test === 1'b1) begin test_cnt++; test_at = c; end
            if (c == rst_at) begin
                @(negedge clk);
                rst = 1'b1;
                bus.strob = 1'b0;
                @(posedge clk);
                #1;
                check("rst_we", 32'(bus.WE), 0);
                check("rst_orb", 32'(bus.orbWord), 0);
                check("rst_addr", 32'(bus.WrAddr), 0);
                check("rst_skip", 32'(bus.skip), 0);
                @(negedge clk);
                rst = 1'b0;
                did_rst = 1'b1;
                break;
            end
            if (c == sw_at) begin @(negedge clk); bus.SW = ~bus.SW; end
            if (c == LAST_HOLD) begin @(negedge clk); bus.strob = 1'b0; end
        end
        bus.strob = 1'b0;
        if (did_rst) begin
            exp_orb = 0;
            exp_addr = 0;
        end else begin
            if (addr != 0 && sw_at == 0) begin
                check("we_rise", first_we, WE_LAT);
                check("we_fall", we_fall, LAST_HOLD + 3);
            end else begin
                check("we_never", first_we, 0);
            end
            check("skip_cnt", skip_cnt, (addr == 0 && sw_at == 0) ? 1 : 0);
            if (skip_cnt == 1) check("skip_at", skip_at, CAPT_CYC);
            check("test_cnt", test_cnt, (sw_at != 0) ? 1 : 0);
            if (test_cnt == 1) check("test_at", test_at, sw_at + 3);
            exp_orb = model_word(lo, hi, md);
            if (addr != 0) exp_addr = addr;
            check("orb_word", 32'(bus.orbWord), exp_orb);
            check("wr_addr", 32'(bus.WrAddr), exp_addr);
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        bus.strob = 1'b0;
        bus.SW = 1'b0;
        bus.iData = '0;
        bus.addrRam = '0;
        bus.mode = 1'b0;
        exp_orb = 0;
        exp_addr = 0;
        repeat (4) @(posedge clk);
        #1;
        check("reset_orb", 32'(bus.orbWord), 0);
        check("reset_addr", 32'(bus.WrAddr), 0);
        check("reset_we", 32'(bus.WE), 0);
        check("reset_test", 32'(bus.test), 0);
        check("reset_skip", 32'(bus.skip), 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed frames from the known-answer table.
        run_frame(8'hA5, 8'h02, 11'h123, 0, 0, 0, 6);
        check("kat_mode0", 32'(bus.orbWord), 32'h54A);
        run_frame(8'hA5, 8'h02, 11'h123, 1, 0, 0, 6);
        check("kat_mode1_hi2", 32'(bus.orbWord), 32'hD4B);
        run_frame(8'hA5, 8'h03, 11'h123, 1, 0, 0, 6);
        check("kat_mode1_hi3", 32'(bus.orbWord), 32'hF4A);

        // Zero address: skip pulse, no write, WrAddr kept.
        run_frame(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 0,
                  int'($urandom_range(0, 1)), 0, 0, 6);

        // Short strobes must not advance the frame; a 4-cycle strobe is accepted.
        pulse(3, 4);
        pulse(3, 4);
        pulse(2, 1);
        pulse(2, 4);
        check("short_no_we", 32'(bus.WE), 0);
        run_frame(8'h3C, 8'h01, 11'h055, 1, 0, 0, QUAL_LEN);

        // SW toggle mid-frame restarts the byte count.
        for (int k = 0; k < 5; k++) begin
            bus.iData = DATA_W'($urandom);
            pulse(6, 4);
        end
        @(negedge clk);
        bus.SW = ~bus.SW;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("sw_test_early", 32'(bus.test), 0);
        @(posedge clk); #1;
        check("sw_test_pulse", 32'(bus.test), 1);
        @(posedge clk); #1;
        check("sw_test_clear", 32'(bus.test), 0);
        repeat (3) @(negedge clk);
        run_frame(8'h81, 8'h02, 11'h400, 0, 0, 0, 6);

        // SW toggle during WESET (count 10) aborts the write.
        run_frame(8'h5A, 8'h01, 11'h2AA, 1, CAPT_CYC + 8, 0, 6);
        run_frame(8'hC3, 8'h03, 11'h7FF, 0, 0, 0, 6);

        // Reset while WE is high, then a normal frame.
        run_frame(8'h11, 8'h02, 11'h321, 1, 0, WE_LAT + 2, 6);
        run_frame(8'hA5, 8'h02, 11'h123, 0, 0, 0, 6);

        // Randomised frames.
        for (int k = 0; k < 3; k++) begin
            run_frame(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                      int'($urandom_range(1, 2047)), int'($urandom_range(0, 1)), 0, 0, 6);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/slow_packer_param.md
Name: slow_packer_param

Overview:
- Parametrised successor of the slow-channel packer. Qualifies each incoming strobe, counts bytes within a frame, and merges two selected bytes into one orbital word.
- Writes that word to orbit RAM at the frame's address, with a programmable write-enable delay.
- Adds a packing-mode select, odd-parity generation, consecutive-high strobe qualification, a zero-address skip indicator and a frame-abort on SW toggle.
- Sits between the slow-data byte source and the orbit RAM write port.

Parameters:
DATA_W, 8, input byte width
WORD_W, 12, orbital word width; HI_BITS = WORD_W-DATA_W-2 must be >=1
ADDR_W, 11, RAM address width
FRAME_LEN, 18, bytes per frame (index 0..FRAME_LEN-1), >=2
LO_IDX, 16, byte index supplying the low byte; must be < FRAME_LEN-1
QUAL_LEN, 4, consecutive synced-strobe-high cycles required to accept a strobe, >=1
WE_DELAY, 28, WESET cycles before WE rises
WE_GUARD, 3, further WESET cycles before leaving WESET

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
iData  in  DATA_W  current frame byte
addrRam  in  ADDR_W  RAM address for the current frame
strob  in  1  asynchronous byte strobe
SW  in  1  asynchronous channel switch
mode  in  1  0 = legacy format, 1 = parity format; sampled at last byte
test  out  1  one-cycle pulse on each synced SW edge
orbWord  out  WORD_W  packed word
WE  out  1  RAM write enable
WrAddr  out  ADDR_W  RAM write address
skip  out  1  one-cycle pulse when a frame completes with addrRam==0

Behaviour:
- Reset: decided, one clock `clk`; reset `rst` is synchronous and active-high. On rst=1 at a clk edge, all of the following clear, mid-operation included, with no partial write completing: orbWord, WrAddr, WE, test, skip, all counters, the lo-byte register and oldSW; state goes to IDLE. The 2-flop synchronisers for strob and SW are not reset.
- Synchronisers: s_str = strob delayed 2 clk; s_sw = SW delayed 2 clk.
- States: IDLE, CAPT, WESET, WAIT.
- IDLE: qual counter increments while s_str=1 and clears when s_str=0. This is new: the count must be consecutive. When the counter reaches QUAL_LEN-1 with s_str=1, clear it and go to CAPT.
- CAPT (one cycle); idx is the byte index:
  - idx < LO_IDX or between LO_IDX and FRAME_LEN-1 (exclusive): idx++ and go to WAIT.
  - idx == LO_IDX: also latch lo <= iData.
  - idx == FRAME_LEN-1: idx <= 0; load orbWord.
    - mode=0: orbWord = {1'b0, iData[HI_BITS-1:0], lo, 1'b0}.
    - mode=1: orbWord = {1'b1, iData[HI_BITS-1:0], lo, p}, where p makes the whole WORD_W word odd parity.
    - If addrRam != 0: WrAddr <= addrRam, clear the WE counter, go to WESET.
    - Else: skip pulses for 1 cycle and go to WAIT; orbWord still updates.
- WESET: WE counter increments each cycle. At count == WE_DELAY, WE goes to 1. At count == WE_DELAY+WE_GUARD, go to WAIT.
- WAIT: when s_str=0, WE goes to 0 and the state returns to IDLE. WE therefore stays high until the strobe falls.
- SW edge (s_sw != oldSW, evaluated every cycle; oldSW <= s_sw):
  - test=1 for one cycle and idx clears to 0.
  - If in CAPT at idx==FRAME_LEN-1 in the same cycle, the SW edge wins: no orbWord or WrAddr update and no skip; go to WAIT.
  - If in WESET: abort to WAIT. WE is not raised, or is held at 0 if already high.
- Widths: idx is clog2(FRAME_LEN) bits; the WE counter is clog2(WE_DELAY+WE_GUARD+1) bits; neither wraps under legal parameters.
- Latency: from strob rising to WE=1 is 2 (sync) + QUAL_LEN + 1 (CAPT) + WE_DELAY + 1 cycles.
- Strobe shorter than QUAL_LEN cycles: ignored and idx unchanged.

Test Plan:
- 18 strobes of 6 cycles each, LO byte=0xA5, last byte=0x02, addrRam=0x123, mode=0 -> orbWord=0x54A (0_10_10100101_0), WrAddr=0x123, WE rises 28+1 cycles after CAPT and falls 1 cycle after s_str drops.
- Same frame with mode=1, LO=0xA5, hi=0x02 -> orbWord=0xD4B (parity bit 1, total odd); repeat with hi=0x03 -> orbWord=0xF4A.
- Frame completing with addrRam=0 -> skip pulses 1 cycle, WE stays 0, orbWord updated, WrAddr unchanged.
- Strobe pulses of 3 cycles, plus a 2-high/1-low/2-high pattern -> no CAPT, idx unchanged; a following 4-cycle pulse is accepted.
- SW toggled during WESET at count 10 -> test pulses 1 cycle, WE never rises, idx=0; the next 18-strobe frame writes normally.
- rst asserted while WE=1 -> on the next edge WE=0, state IDLE, orbWord=0, WrAddr=0; after release a full frame packs correctly.
